// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU
// replacement and a handshaked write-back/refill miss FSM.
module set_assoc_cache #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned NUM_SETS        = 4,
  parameter int unsigned NUM_WAYS        = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rd_en,
  input  logic                                  wr_en,
  input  logic [31:0]                           addr,
  input  logic [DATA_WIDTH-1:0]                 WriteData,
  input  logic [2:0]                            funct3,
  output logic [DATA_WIDTH-1:0]                 cache_read,
  output logic                                  stall,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [31:0]                           mem_addr,
  output logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] mem_wdata,
  input  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] mem_rdata,
  input  logic                                  mem_ready
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = 32 - 2 - OFF_W - IDX_W;
  localparam int unsigned AGE_W  = $clog2(NUM_WAYS);
  localparam int unsigned LINE_W = WORDS_PER_BLOCK * DATA_WIDTH;
  localparam logic [OFF_W+1:0] ZERO_OFF = '0;
  localparam logic [AGE_W-1:0] AGE_LRU  = AGE_W'(NUM_WAYS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_e;

  state_e state_q, state_d;
  logic [AGE_W-1:0]  vic_q, vic_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic              valid_q [NUM_SETS][NUM_WAYS];
  logic              dirty_q [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0]  age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             access;

  assign off    = addr[2 +: OFF_W];
  assign idx    = addr[2+OFF_W +: IDX_W];
  assign tag    = addr[31 -: TAG_W];
  assign access = rd_en | wr_en;

  // Tag lookup
  logic             hit;
  logic [AGE_W-1:0] hit_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, else the LRU way
  logic             inv_found;
  logic [AGE_W-1:0] vic_way;
  always_comb begin
    inv_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        vic_way   = AGE_W'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[idx][w] == AGE_LRU) vic_way = AGE_W'(w);
      end
    end
  end

  logic [LINE_W-1:0]     hit_line;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign hit_line = data_q[idx][hit_way];
  assign hit_word = hit_line[{off, 5'b00000} +: DATA_WIDTH];
  assign ld_byte  = hit_word[{addr[1:0], 3'b000} +: 8];
  assign ld_half  = hit_word[{addr[1], 4'b0000} +: 16];

  // Load extraction and extension
  always_comb begin
    case (funct3)
      3'b000:  cache_read = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  cache_read = {{16{ld_half[15]}}, ld_half};
      3'b010:  cache_read = hit_word;
      3'b100:  cache_read = {24'd0, ld_byte};
      3'b101:  cache_read = {16'd0, ld_half};
      default: cache_read = '0;
    endcase
  end

  // Store merge into the addressed lanes
  logic [DATA_WIDTH-1:0] st_word;
  logic [LINE_W-1:0]     st_line;
  always_comb begin
    st_word = hit_word;
    case (funct3)
      3'b000:  st_word[{addr[1:0], 3'b000} +: 8] = WriteData[7:0];
      3'b001:  st_word[{addr[1], 4'b0000} +: 16] = WriteData[15:0];
      3'b010:  st_word = WriteData;
      default: st_word = hit_word;
    endcase
    st_line = hit_line;
    st_line[{off, 5'b00000} +: DATA_WIDTH] = st_word;
  end

  // Miss FSM next-state and registered memory-side outputs
  logic hit_upd, store_upd, fill_upd;
  always_comb begin
    state_d   = state_q;
    vic_d     = vic_q;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    hit_upd   = 1'b0;
    store_upd = 1'b0;
    fill_upd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (hit) begin
            hit_upd   = 1'b1;
            store_upd = wr_en;
          end else begin
            vic_d = vic_way;
            req_d = 1'b1;
            if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
              state_d = S_WB;
              we_d    = 1'b1;
              maddr_d = {tag_q[idx][vic_way], idx, ZERO_OFF};
              wdata_d = data_q[idx][vic_way];
            end else begin
              state_d = S_FILL;
              we_d    = 1'b0;
              maddr_d = {tag, idx, ZERO_OFF};
            end
          end
        end
      end
      S_WB: begin
        if (mem_ready) begin
          state_d = S_FILL;
          we_d    = 1'b0;
          maddr_d = {tag, idx, ZERO_OFF};
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          fill_upd = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LRU ages: accessed way becomes MRU, younger ways age by one
  logic [AGE_W-1:0] acc_way;
  logic [AGE_W-1:0] new_age [NUM_WAYS];
  always_comb begin
    acc_way = fill_upd ? vic_q : hit_way;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (AGE_W'(w) == acc_way)                  new_age[w] = '0;
      else if (age_q[idx][w] < age_q[idx][acc_way]) new_age[w] = age_q[idx][w] + 1'b1;
      else                                       new_age[w] = age_q[idx][w];
    end
  end

  assign stall = ~rst & ((state_q != S_IDLE) | (access & ~hit));

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vic_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      vic_q   <= vic_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Line status: valid, dirty, age
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (fill_upd) begin
        valid_q[idx][vic_q] <= 1'b1;
        dirty_q[idx][vic_q] <= 1'b0;
      end
      if (store_upd) dirty_q[idx][hit_way] <= 1'b1;
      if (hit_upd || fill_upd) begin
        for (int w = 0; w < NUM_WAYS; w++) age_q[idx][w] <= new_age[w];
      end
    end
  end

  // Tag and data arrays carry no reset
  always_ff @(posedge clk) begin
    if (fill_upd) begin
      tag_q[idx][vic_q]  <= tag;
      data_q[idx][vic_q] <= mem_rdata;
    end else if (store_upd) begin
      data_q[idx][hit_way] <= st_line;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed scenarios followed by
// random accesses, all checked against a line/LRU-list reference model.
module tb_set_assoc_cache;

  localparam int WPB    = 4;
  localparam int NS     = 4;
  localparam int NW     = 2;
  localparam int LINE_W = WPB * 32;
  localparam int OFFB   = $clog2(WPB);
  localparam int BLKB   = WPB * 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0]       addr = '0, WriteData = '0;
  logic [2:0]        funct3 = 3'b010;
  logic [31:0]       cache_read;
  logic              stall, mem_req, mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;

  set_assoc_cache #(.DATA_WIDTH(32), .WORDS_PER_BLOCK(WPB), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .WriteData(WriteData), .funct3(funct3), .cache_read(cache_read), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_wb_addr, last_wb_w0, last_fill_addr;

  // Reference model: per-way block address/data, LRU kept as an ordered list
  bit          mv   [NS][NW];
  bit          md   [NS][NW];
  logic [31:0] mblk [NS][NW];
  logic [31:0] mdat [NS][NW][WPB];
  int          mord [NS][$];
  logic [31:0] mem  [int];

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int widx);
    if (!mem.exists(widx)) mem[widx] = $urandom;
    return mem[widx];
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] blk);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WPB; i++) l[32*i +: 32] = mem_rd(int'(blk >> 2) + i);
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      mord[s].delete();
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
        mord[s].push_back(w);
      end
    end
  endtask

  task automatic touch(input int s, input int w);
    int k;
    k = 0;
    for (int i = 0; i < mord[s].size(); i++) if (mord[s][i] == w) k = i;
    mord[s].delete(k);
    mord[s].push_front(w);
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, output bit hit, output bit wb,
                              output logic [31:0] wb_addr, output logic [LINE_W-1:0] wb_line,
                              output logic [31:0] fill_addr, output logic [31:0] ld);
    int s, way, wi;
    logic [31:0] blk, word, bl, hl, mask;
    s   = int'((a >> (2 + OFFB)) % NS);
    blk = a & ~32'(BLKB - 1);
    wi  = int'((a >> 2) % WPB);
    hit = 0; wb = 0; wb_addr = '0; wb_line = '0; fill_addr = blk; way = -1;
    for (int w = 0; w < NW; w++) if (mv[s][w] && mblk[s][w] == blk) begin hit = 1; way = w; end
    if (!hit) begin
      for (int w = 0; w < NW; w++) if (!mv[s][w] && way < 0) way = w;
      if (way < 0) way = mord[s][mord[s].size()-1];
      if (mv[s][way] && md[s][way]) begin
        wb = 1;
        wb_addr = mblk[s][way];
        for (int i = 0; i < WPB; i++) begin
          wb_line[32*i +: 32] = mdat[s][way][i];
          mem[int'(wb_addr >> 2) + i] = mdat[s][way][i];
        end
      end
      for (int i = 0; i < WPB; i++) mdat[s][way][i] = mem_rd(int'(blk >> 2) + i);
      mv[s][way] = 1; md[s][way] = 0; mblk[s][way] = blk;
      touch(s, way);
    end
    touch(s, way);
    word = mdat[s][way][wi];
    bl = (word >> (8 * a[1:0])) & 32'hFF;
    hl = (word >> (16 * a[1])) & 32'hFFFF;
    ld = '0;
    if (wr) begin
      md[s][way] = 1;
      case (f3)
        3'b000: begin mask = 32'hFF << (8 * a[1:0]);   word = (word & ~mask) | ((wd << (8 * a[1:0])) & mask); end
        3'b001: begin mask = 32'hFFFF << (16 * a[1]); word = (word & ~mask) | ((wd << (16 * a[1])) & mask); end
        3'b010: word = wd;
        default: ;
      endcase
      mdat[s][way][wi] = word;
    end else begin
      case (f3)
        3'b000: ld = (bl >= 128) ? (bl | 32'hFFFFFF00) : bl;
        3'b001: ld = (hl >= 32768) ? (hl | 32'hFFFF0000) : hl;
        3'b010: ld = word;
        3'b100: ld = bl;
        3'b101: ld = hl;
        default: ld = '0;
      endcase
    end
  endtask

  // One access: serve memory transfers with 'dly' wait cycles per phase
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int dly, output logic [31:0] rdata, output int sc);
    bit ehit, ewb;
    logic [31:0] ewb_addr, efill, eld;
    logic [LINE_W-1:0] ewb_line;
    int phase, waitc, exp_sc;
    model_access(wr, a, wd, f3, ehit, ewb, ewb_addr, ewb_line, efill, eld);
    exp_sc = ehit ? 0 : (1 + (dly + 1) + (ewb ? dly + 1 : 0));
    @(negedge clk);
    rd_en = ~wr; wr_en = wr; addr = a; WriteData = wd; funct3 = f3; mem_ready = 1'b0;
    #1;
    sc = 0; phase = ewb ? 0 : 1; waitc = 0;
    while (stall === 1'b1 && sc < 100) begin
      if (sc == 0) chk("req_in_miss_cycle", mem_req, 0);
      else begin
        chk("req_held", mem_req, 1);
        chk("mem_we", mem_we, (phase == 0));
        chk("mem_addr", mem_addr, (phase == 0) ? ewb_addr : efill);
        if (phase == 0) begin
          chk("mem_wdata", mem_wdata, ewb_line);
          last_wb_addr = mem_addr;
          last_wb_w0 = mem_wdata[31:0];
        end else last_fill_addr = mem_addr;
        if (waitc >= dly) begin
          mem_ready = 1'b1;
          mem_rdata = mem_line(efill);
          phase++;
          waitc = 0;
        end else waitc++;
      end
      sc++;
      @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", sc, exp_sc);
    chk("req_in_hit_cycle", mem_req, 0);
    if (!wr) chk("load_data", cache_read, eld);
    rdata = cache_read;
  endtask

  initial begin
    logic [31:0] rd;
    int sc;
    bit w;
    model_reset();
    mem[32'h100 >> 2] = 32'h11223344;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // Cold load miss
    access(0, 32'h100, 0, 3'b010, 0, rd, sc);
    chk("t1_stall", sc, 2);
    chk("t1_data", rd, 32'h11223344);
    chk("t1_fill_addr", last_fill_addr, 32'h100);

    // Byte and halfword lanes on a resident line
    access(1, 32'h105, 32'hAB, 3'b000, 0, rd, sc);
    chk("t2_sb_stall", sc, 0);
    access(0, 32'h105, 0, 3'b100, 0, rd, sc);
    chk("t2_lbu", rd, 32'h000000AB);
    access(0, 32'h105, 0, 3'b000, 0, rd, sc);
    chk("t2_lb", rd, 32'hFFFFFFAB);
    access(1, 32'h106, 32'h8001, 3'b001, 0, rd, sc);
    access(0, 32'h106, 0, 3'b001, 0, rd, sc);
    chk("t2_lh", rd, 32'hFFFF8001);

    // LRU in set 0
    access(0, 32'h000, 0, 3'b010, 0, rd, sc);
    access(0, 32'h040, 0, 3'b010, 0, rd, sc);
    access(0, 32'h000, 0, 3'b010, 0, rd, sc);
    chk("t3_hit_000", sc, 0);
    access(0, 32'h080, 0, 3'b010, 0, rd, sc);
    chk("t3_no_wb_080", sc, 2);
    access(0, 32'h000, 0, 3'b010, 0, rd, sc);
    chk("t3_still_hit_000", sc, 0);
    access(0, 32'h040, 0, 3'b010, 0, rd, sc);
    chk("t3_miss_040", sc, 2);

    // Dirty eviction
    access(1, 32'h040, 32'hDEADBEEF, 3'b010, 0, rd, sc);
    access(0, 32'h080, 0, 3'b010, 0, rd, sc);
    access(0, 32'h0C0, 0, 3'b010, 0, rd, sc);
    chk("t4_stall", sc, 3);
    chk("t4_wb_addr", last_wb_addr, 32'h040);
    chk("t4_wb_word0", last_wb_w0, 32'hDEADBEEF);
    chk("t4_fill_addr", last_fill_addr, 32'h0C0);

    // Slow memory
    access(0, 32'h130, 0, 3'b010, 5, rd, sc);
    chk("t5_stall", sc, 7);

    // Reset during a refill
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; addr = 32'h230; funct3 = 3'b010; mem_ready = 1'b0;
    #1 chk("t6_miss_stall", stall, 1);
    @(negedge clk);
    #1 chk("t6_fill_req", mem_req, 1);
    chk("t6_fill_we", mem_we, 0);
    #2 rst = 1'b1;
    #1 chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_addr", mem_addr, 0);
    @(negedge clk);
    rd_en = 1'b0;
    rst = 1'b0;
    model_reset();
    access(0, 32'h130, 0, 3'b010, 0, rd, sc);
    chk("t6_reaccess_miss", sc, 2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 2) == 0);
      access(w, $urandom_range(0, 32'h3FF), $urandom, 3'($urandom_range(0, 7)),
             $urandom_range(0, 3), rd, sc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
